// File: rtl/mbist_march_sequencer.sv
// mbist_march_sequencer: March C- sequencer over one single-port SRAM with pipelined read compare and first-fail capture
module mbist_march_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              NbarT,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  localparam logic [2:0] ELEM_END = 3'd6;
  logic [1:0] state;
  logic [2:0] elem, op_elem, dcnt;
  logic [ADDR_W-1:0] addr;
  logic op, op_bg;
  logic [RD_LAT-1:0] pv, pbg;
  logic [ADDR_W-1:0] pa [RD_LAT];
  logic [2:0] pe [RD_LAT];
  logic launch, issue, two_op, down, is_wr, rd_bg, wr_bg, last_a, nxt_down, mismatch;
  // elem/addr/op always name the next op to issue; they rest at zero outside RUN
  always_comb begin
    launch   = (state == IDLE || state == DONE) && start;
    issue    = launch || (state == RUN && elem != ELEM_END);
    two_op   = elem >= 3'd1 && elem <= 3'd4;
    down     = elem == 3'd3 || elem == 3'd4;
    nxt_down = elem == 3'd2 || elem == 3'd3;
    is_wr    = elem == 3'd0 || (two_op && op);
    rd_bg    = elem == 3'd2 || elem == 3'd4;
    wr_bg    = elem == 3'd1 || elem == 3'd3;
    last_a   = down ? addr == '0 : addr == ADDR_W'(DEPTH - 1);
    mismatch = pv[RD_LAT-1] && mem_rdata != {DATA_W{pbg[RD_LAT-1]}};
  end
  assign NbarT = state == RUN || state == DRAIN;
  assign busy  = NbarT;
  assign done  = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= '0;
      addr      <= '0;
      op        <= 1'b0;
      dcnt      <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_wdata <= '0;
      op_elem   <= '0;
      op_bg     <= 1'b0;
      pv        <= '0;
      pbg       <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      mem_we    <= issue && is_wr;
      mem_re    <= issue && !is_wr;
      mem_addr  <= issue ? addr : '0;
      mem_wdata <= (issue && is_wr) ? {DATA_W{wr_bg}} : '0;
      op_elem   <= elem;
      op_bg     <= rd_bg;
      if (issue) begin
        if (two_op && !op) op <= 1'b1;
        else begin
          op <= 1'b0;
          if (last_a) begin
            elem <= elem + 3'd1;
            addr <= nxt_down ? ADDR_W'(DEPTH - 1) : '0;
          end else addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
      end
      pv[0]  <= mem_re;
      pbg[0] <= op_bg;
      pa[0]  <= mem_addr;
      pe[0]  <= op_elem;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pbg[i] <= pbg[i-1];
        pa[i]  <= pa[i-1];
        pe[i]  <= pe[i-1];
      end
      if (launch) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
      end else if (mismatch && !fail) begin
        fail      <= 1'b1;
        fail_addr <= pa[RD_LAT-1];
        fail_elem <= pe[RD_LAT-1];
      end
      if (launch) state <= RUN;
      else if (state == RUN && elem == ELEM_END) begin
        state <= DRAIN;
        elem  <= '0;
        dcnt  <= '0;
      end else if (state == DRAIN) begin
        state <= (dcnt == 3'(RD_LAT - 1)) ? DONE : DRAIN;
        dcnt  <= dcnt + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_mbist_march_sequencer.sv
// tb_mbist_march_sequencer: scoreboard bench for two sequencer configurations with fault-injecting memory models
module tb_mbist_march_sequencer;
  logic clk = 1'b0, rst = 1'b1, sa = 1'b0, sb = 1'b0;
  always #5 clk = ~clk;
  logic a_nbart, a_we, a_re, a_busy, a_done, a_fail;
  logic [3:0] a_addr, a_faddr;
  logic [7:0] a_wdata, rda;
  logic [2:0] a_felem;
  logic b_nbart, b_we, b_re, b_busy, b_done, b_fail;
  logic [3:0] b_addr, b_faddr;
  logic [7:0] b_wdata, rb1, rb2, rb3;
  logic [2:0] b_felem;
  mbist_march_sequencer #(.DEPTH(16), .ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(sa), .mem_rdata(rda), .NbarT(a_nbart), .mem_addr(a_addr),
    .mem_we(a_we), .mem_re(a_re), .mem_wdata(a_wdata), .busy(a_busy), .done(a_done),
    .fail(a_fail), .fail_addr(a_faddr), .fail_elem(a_felem));
  mbist_march_sequencer #(.DEPTH(10), .ADDR_W(4), .DATA_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(sb), .mem_rdata(rb3), .NbarT(b_nbart), .mem_addr(b_addr),
    .mem_we(b_we), .mem_re(b_re), .mem_wdata(b_wdata), .busy(b_busy), .done(b_done),
    .fail(b_fail), .fail_addr(b_faddr), .fail_elem(b_felem));
  logic [7:0] mema [16], memb [16], sa1a [16], sa0a [16];
  always @(posedge clk) begin
    if (a_we) mema[a_addr] <= a_wdata;
    if (a_re) rda <= (mema[a_addr] | sa1a[a_addr]) & ~sa0a[a_addr];
    if (b_we) memb[b_addr] <= b_wdata;
    if (b_re) rb1 <= memb[b_addr];
    rb2 <= rb1;
    rb3 <= rb2;
  end
  int pass_n = 0, tot_n = 0;
  task automatic chk(input string n, input int got, input int exp);
    tot_n++;
    if (got == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", n, got, exp);
  endtask
  typedef struct {int f; int fa; int fe; int lat;} res_t;
  logic [13:0] qa [$], qb [$];
  res_t ra [$], rb [$];
  task automatic put(input int sel, input logic we, input int a, input logic [7:0] d);
    logic [13:0] v;
    v = {we, ~we, 4'(a), we ? d : 8'h00};
    if (sel == 0) qa.push_back(v);
    else qb.push_back(v);
  endtask
  // March C-: w0^ ; (r0,w1)^ ; (r1,w0)^ ; (r0,w1)v ; (r1,w0)v ; r0^
  task automatic push_ops(input int sel, input int d);
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < d; k++) begin
        int a;
        a = (e == 3 || e == 4) ? d - 1 - k : k;
        if (e == 0) put(sel, 1'b1, a, 8'h00);
        else if (e == 5) put(sel, 1'b0, a, 8'h00);
        else begin
          put(sel, 1'b0, a, 8'h00);
          put(sel, 1'b1, a, (e == 1 || e == 3) ? 8'hFF : 8'h00);
        end
      end
  endtask
  int na = 0, ta = 0, nb = 0, tb = 0, maxb = 0;
  logic pn_a = 1'b0, pd_a = 1'b0, pn_b = 1'b0, pd_b = 1'b0;
  logic [13:0] ga, ea, gb, eb;
  res_t resa, resb;
  always @(negedge clk) begin
    na++;
    if (a_we | a_re) begin
      chk("a_we_re_excl", int'(a_we & a_re), 0);
      if (qa.size() == 0) chk("a_unexpected_op", 1, 0);
      else begin
        ga = {a_we, a_re, a_addr, a_we ? a_wdata : 8'h00};
        ea = qa.pop_front();
        chk("a_op", int'(ga), int'(ea));
      end
    end
    if (a_nbart && !pn_a) ta = na;
    if (a_done && !pd_a) begin
      if (ra.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        resa = ra.pop_front();
        chk("a_latency", na - ta, resa.lat);
        chk("a_fail", int'(a_fail), resa.f);
        chk("a_fail_addr", int'(a_faddr), resa.fa);
        chk("a_fail_elem", int'(a_felem), resa.fe);
        chk("a_ops_left", qa.size(), 0);
      end
    end
    pn_a = a_nbart;
    pd_a = a_done;
  end
  always @(negedge clk) begin
    nb++;
    if (b_we | b_re) begin
      chk("b_we_re_excl", int'(b_we & b_re), 0);
      if (int'(b_addr) > maxb) maxb = int'(b_addr);
      if (qb.size() == 0) chk("b_unexpected_op", 1, 0);
      else begin
        gb = {b_we, b_re, b_addr, b_we ? b_wdata : 8'h00};
        eb = qb.pop_front();
        chk("b_op", int'(gb), int'(eb));
      end
    end
    if (b_nbart && !pn_b) tb = nb;
    if (b_done && !pd_b) begin
      if (rb.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        resb = rb.pop_front();
        chk("b_latency", nb - tb, resb.lat);
        chk("b_fail", int'(b_fail), resb.f);
        chk("b_max_addr", maxb, 9);
        chk("b_ops_left", qb.size(), 0);
      end
    end
    pn_b = b_nbart;
    pd_b = b_done;
  end
  task automatic run(input int sel, input int budget);
    int i;
    @(posedge clk);
    #1;
    if (sel == 0) sa = 1'b1;
    else sb = 1'b1;
    @(posedge clk);
    #1;
    sa = (sel == 0) ? 1'b0 : sa;
    sb = (sel == 1) ? 1'b0 : sb;
    chk("run_entry_busy", int'(sel == 0 ? a_busy : b_busy), 1);
    chk("run_entry_fail_clear", int'(sel == 0 ? a_fail : b_fail), 0);
    i = 0;
    while (i < budget && !(sel == 0 ? a_done : b_done)) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", int'(sel == 0 ? a_done : b_done), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", int'(sel == 0 ? a_done : b_done), 1);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      mema[i] = 8'h00;
      memb[i] = 8'h00;
      sa1a[i] = 8'h00;
      sa0a[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("a_reset_outs", int'({a_nbart, a_addr, a_we, a_re, a_wdata, a_busy, a_done, a_fail, a_faddr, a_felem}), 0);
    chk("b_reset_outs", int'({b_nbart, b_addr, b_we, b_re, b_wdata, b_busy, b_done, b_fail, b_faddr, b_felem}), 0);
    rst = 1'b0;
    fork
      begin
        push_ops(1, 10);
        rb.push_back('{0, 0, 0, 103});
        run(1, 400);
      end
      begin
        push_ops(0, 16);
        ra.push_back('{0, 0, 0, 161});
        run(0, 400);
        sa1a[5] = 8'h01;
        push_ops(0, 16);
        ra.push_back('{1, 5, 1, 161});
        run(0, 400);
        sa1a[5] = 8'h00;
        sa0a[3] = 8'h80;
        sa0a[9] = 8'h80;
        push_ops(0, 16);
        ra.push_back('{1, 3, 2, 161});
        run(0, 400);
        sa0a[3] = 8'h00;
        sa0a[9] = 8'h00;
        push_ops(0, 16);
        ra.push_back('{0, 0, 0, 161});
        run(0, 400);
        push_ops(0, 16);
        @(posedge clk);
        #1 sa = 1'b1;
        @(posedge clk);
        #1 sa = 1'b0;
        repeat (20) @(posedge clk);
        #1 sa = 1'b1;
        @(posedge clk);
        #1 sa = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("a_abort_outs", int'({a_nbart, a_addr, a_we, a_re, a_wdata, a_busy, a_done, a_fail, a_faddr, a_felem}), 0);
        chk("a_abort_ops_left", qa.size(), 119);
        qa.delete();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("a_idle_after_abort", int'({a_nbart, a_we, a_re, a_done}), 0);
      end
    join
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
